// File: rtl/seg_pkg.sv
// Shared definitions for the scanned seven-segment display: segment glyphs
// (gfedcba, active-high), digit-slot names and the decoder's special codes.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_U     = 7'b0111110;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Decoder codes beyond the decimal digits
    localparam logic [3:0] CODE_U     = 4'd10;
    localparam logic [3:0] CODE_D     = 4'd11;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Digit slot index; slot 0 is the rightmost digit
    typedef enum logic [1:0] {
        DIG_ONES  = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_SPARE = 2'd2,
        DIG_DIR   = 2'd3
    } dig_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational map of a 4-bit display code to seven segments.
// 0..9 are decimal digits, 10 = "U", 11 = "d", everything else is blank.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    // Code-to-glyph lookup
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            CODE_U:  o_seg = SEG_U;
            CODE_D:  o_seg = SEG_D;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_scan_display.sv
// Four-digit multiplexed seven-segment driver for the up/down counter.
// Shows the counter value in decimal with a direction letter, and blanks
// the segments for a number of frames after the counter wraps.
module count_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic       cp,
    input  logic       reset,
    input  logic [3:0] count,
    input  logic       dir,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       wrap_flag
);

    localparam int unsigned      PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
    localparam logic [7:0]       FL_LOAD = 8'(FLASH_FRAMES);

    logic [PRE_W-1:0] r_pre;
    dig_t             r_dig;
    logic [3:0]       r_snap_val;
    logic             r_snap_dir;
    logic [3:0]       r_prev;
    logic [7:0]       r_fl;

    logic             w_tick;
    logic             w_frame_start;
    dig_t             w_dig_next;
    logic [3:0]       w_val;
    logic             w_dir;
    logic [3:0]       w_code;
    logic [6:0]       w_seg;
    logic [3:0]       w_an_next;
    logic             w_wrap;
    logic [7:0]       w_fl_next;

    // Slot timing, digit selection, wrap detection and blanking-counter next state
    always_comb begin
        w_tick        = (r_pre == PRE_MAX);
        w_dig_next    = dig_t'(r_dig + 2'd1);
        w_frame_start = w_tick && (r_dig == DIG_DIR);

        // At frame start the digit about to be shown uses the value being captured now
        w_val = w_frame_start ? count : r_snap_val;
        w_dir = w_frame_start ? dir   : r_snap_dir;

        w_code = CODE_BLANK;
        case (w_dig_next)
            DIG_ONES:  w_code = (w_val >= 4'd10) ? (w_val - 4'd10) : w_val;
            DIG_TENS:  w_code = (w_val >= 4'd10) ? 4'd1 : CODE_BLANK;
            DIG_SPARE: w_code = CODE_BLANK;
            DIG_DIR:   w_code = w_dir ? CODE_U : CODE_D;
            default:   w_code = CODE_BLANK;
        endcase

        w_an_next = 4'b0001 << w_dig_next;

        w_wrap = ( dir && (r_prev == 4'd15) && (count == 4'd0)) ||
                 (!dir && (r_prev == 4'd0)  && (count == 4'd15));

        w_fl_next = r_fl;
        if (w_wrap)
            w_fl_next = FL_LOAD;
        else if (w_frame_start && (r_fl != '0))
            w_fl_next = r_fl - 8'd1;
    end

    seg_decode u_seg_decode (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    // Prescaler and digit index
    always_ff @(posedge cp or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
            r_dig <= DIG_DIR;
        end else if (w_tick) begin
            r_pre <= '0;
            r_dig <= w_dig_next;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Per-frame snapshot of the counter, and the one-cycle-old count for wrap detection
    always_ff @(posedge cp or negedge reset) begin
        if (!reset) begin
            r_snap_val <= '0;
            r_snap_dir <= 1'b0;
            r_prev     <= '0;
        end else begin
            r_prev <= count;
            if (w_frame_start) begin
                r_snap_val <= count;
                r_snap_dir <= dir;
            end
        end
    end

    // Blanking counter; the flag is registered from the same next-state value
    always_ff @(posedge cp or negedge reset) begin
        if (!reset) begin
            r_fl      <= '0;
            wrap_flag <= 1'b0;
        end else begin
            r_fl      <= w_fl_next;
            wrap_flag <= (w_fl_next != '0);
        end
    end

    // Pin registers: anodes step on each tick; segments blank whenever blanking is active
    always_ff @(posedge cp or negedge reset) begin
        if (!reset) begin
            an  <= '0;
            seg <= SEG_BLANK;
        end else begin
            if (w_tick)
                an <= w_an_next;
            // Blanking only ends at a frame start (a tick), so holding between ticks is safe
            if (w_fl_next != '0)
                seg <= SEG_BLANK;
            else if (w_tick)
                seg <= w_seg;
        end
    end

endmodule

// File: doc/count_scan_display.md
# count_scan_display

Time-multiplexed four-digit seven-segment driver placed directly downstream of the up/down counter. It consumes the counter's 4-bit value and direction, and shows the value as a decimal number with the direction letter. When the counter wraps, it blanks the display for a programmable number of frames. All digit and segment outputs are registered and go straight to board pins.

## Interface
- SCAN_DIV, 50000: `cp` cycles per digit slot; legal range 2..2^20.
- FLASH_FRAMES, 8: full scan frames blanked after a wrap; legal range 1..255.
- cp  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately; release is synchronous to `cp`.
- count  input  4  counter value; changes at most once per `cp`.
- dir  input  1  counter direction: 1 = up, 0 = down.
- an  output  4  digit enables, active-high, one-hot while scanning; an[0] is the rightmost digit.
- seg  output  7  segments, active-high; seg[0] = a … seg[6] = g.
- wrap_flag  output  1  high while a wrap blanking period is active.

## Operation
- Prescaler `pre` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted in the cycle where pre == SCAN_DIV-1.
- Digit index `dig` (2 bits) advances on each tick: 0→1→2→3→0.
- Frame start is the tick where dig goes 3→0. At frame start, {count, dir} is captured into a snapshot. All four digits show the same snapshot for the whole frame, so no tearing.
- Digit contents, derived from snapshot value v:
  - dig 0: ones digit, (v ≥ 10) ? v−10 : v.
  - dig 1: tens digit, shows "1" when v ≥ 10, otherwise blank.
  - dig 2: always blank.
  - dig 3: direction letter, "U" (seg = 7'b0111110) when dir = 1, "d" (seg = 7'b1011110) when dir = 0.
- Digit encodings (gfedcba): 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111, blank = 0000000.
- Wrap detect runs every cycle against `prev` (count registered one cycle earlier):
  - up wrap: dir = 1, prev = 15, count = 0.
  - down wrap: dir = 0, prev = 0, count = 15.
  - Any other transition is not a wrap.
- Blanking counter `fl` (8 bits):
  - A wrap loads FLASH_FRAMES.
  - Otherwise, each frame start decrements fl while it is nonzero.
  - If a wrap and a frame start occur in the same cycle, the load wins.
  - A wrap while fl is nonzero reloads FLASH_FRAMES.
- wrap_flag = (fl ≠ 0). While wrap_flag is high, seg is forced to 0; `an` keeps scanning.

## Timing
- Reset values: pre = 0, dig = 3, snapshot = 0/dir 0, prev = 0, fl = 0, an = 4'b0000, seg = 7'b0000000, wrap_flag = 0.
- dig resets to 3, so the first tick after reset is a frame start. That tick selects digit 0 using a snapshot taken that same cycle.
- an and seg update one cycle after each tick, and both change in the same edge.
- First non-zero `an` appears SCAN_DIV+1 cycles after reset release.
- wrap_flag rises one cycle after the cycle in which the wrapping value appears on `count` (that value is first registered as prev then).
- Blanking duration is FLASH_FRAMES or FLASH_FRAMES+1 frames, depending on frame phase at the wrap.
- Asserting reset mid-frame zeroes an/seg/wrap_flag asynchronously. No partial frame resumes.

## Structure
- Package `seg_pkg`:
  - segment constants SEG_0..SEG_9, SEG_U, SEG_D, SEG_BLANK.
  - digit index typedef (2-bit) and digit-slot names DIG_ONES, DIG_TENS, DIG_SPARE, DIG_DIR.
- Sub-module `seg_decode`: combinational map of 4-bit code to 7-bit segments. Codes 10 = U, 11 = d, 15 = blank, 12–14 = blank. The top level selects the code per digit.
- Top level holds the prescaler, digit index, snapshot, prev, blanking counter and output registers.

## Test plan
Run with SCAN_DIV = 4 and FLASH_FRAMES = 2.
1. Reset held then released, count = 7, dir = 1 → an/seg = 0 for 4 cycles. Then an = 0001/seg = 0000111, then 0010/0000000, then 0100/0000000, then 1000/0111110, repeating every 16 cycles.
2. count = 13, dir = 0 → digit 0 seg = 1001111, digit 1 seg = 0000110, digit 3 seg = 1011110.
3. count changes 5→6 mid-frame → all remaining digits of that frame still show 5; digit 0 shows 6 from the next frame start.
4. dir = 1, count 15→0 → wrap_flag high one cycle later. seg = 0 on every slot for 2–3 frames while an keeps scanning. wrap_flag then drops and "0 … U" returns.
5. dir = 0, count 0→15, with a second wrap (15→0 up) injected during blanking → fl reloaded and blanking extended. A 3→4 step causes no wrap.
6. reset pulsed low mid-frame with wrap_flag high → an, seg and wrap_flag go 0 asynchronously. After release, behaviour is identical to scenario 1.
